// File: rtl/bombe_step_if.sv
// Handshake and rotor-bank bundle between the bombe step controller and its environment.
interface bombe_step_if #(
    parameter int NUM_ROTORS = 3
);
    logic                      start;
    logic                      abort;
    logic                      resume;
    logic                      stop_in;
    logic [5*NUM_ROTORS-1:0]   init_state;
    logic                      rotor_load;
    logic [5*NUM_ROTORS-1:0]   rotor_init;
    logic [NUM_ROTORS-1:0]     rotor_increment;
    logic [5*NUM_ROTORS-1:0]   position;
    logic                      running;
    logic                      stop_hit;
    logic                      done;
    logic [7:0]                stop_count;

    modport master (
        output start, abort, resume, stop_in, init_state,
        input  rotor_load, rotor_init, rotor_increment, position,
        input  running, stop_hit, done, stop_count
    );

    modport slave (
        input  start, abort, resume, stop_in, init_state,
        output rotor_load, rotor_init, rotor_increment, position,
        output running, stop_hit, done, stop_count
    );
endinterface

// File: rtl/bombe_step_controller.sv
// Odometer-style step sequencer for a chain of clocked rotors, with stop/resume and sweep completion.
// Optional macro BOMBE_STOP_COUNT_EN builds the per-sweep stop counter; otherwise stop_count is 0.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start
// S_LOAD    | one-cycle load pulse to the rotor bank
// S_SETTLE  | waiting SETTLE_CYCLES for downstream stop-test to settle
// S_CHECK   | sample stop_in, decide stop / done / step
// S_STEP    | one-cycle increment pulses with carry chain
// S_STOPPED | candidate found, waiting for resume
// S_DONE    | every position visited, waiting for start
module bombe_step_controller #(
    parameter int NUM_ROTORS    = 3,
    parameter int ROTOR_MOD     = 26,
    parameter int SETTLE_CYCLES = 2
) (
    input logic         clk,
    input logic         resetn,
    bombe_step_if.slave bus
);

    localparam int              POS_W      = 5 * NUM_ROTORS;
    localparam int              TOTAL      = ROTOR_MOD ** NUM_ROTORS;
    localparam logic [POS_W-1:0] FINAL_CNT = POS_W'(TOTAL - 1);
    localparam logic [4:0]      ROTOR_LAST = 5'(ROTOR_MOD - 1);
    localparam logic [3:0]      SETTLE_LD  = 4'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_STEP, S_STOPPED, S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              wait_q, wait_d;
    logic [POS_W-1:0]        step_cnt_q, step_cnt_d;
    logic                    rotor_load_q, rotor_load_d;
    logic [POS_W-1:0]        rotor_init_q, rotor_init_d;
    logic [NUM_ROTORS-1:0]   rotor_inc_q, rotor_inc_d;
    logic [POS_W-1:0]        position_q, position_d;
    logic                    running_q, running_d;
    logic                    stop_hit_q, stop_hit_d;
    logic                    done_q, done_d;

    logic [NUM_ROTORS-1:0]   step_mask;
    logic                    carry;
    logic [POS_W-1:0]        stepped_pos;

    // Rotor i steps only when every faster rotor sits on its last position.
    always_comb begin
        step_mask = '0;
        carry     = 1'b1;
        for (int i = 0; i < NUM_ROTORS; i++) begin
            step_mask[i] = carry;
            carry        = carry & (position_q[5*i +: 5] == ROTOR_LAST);
        end
    end

    always_comb begin
        stepped_pos = position_q;
        for (int i = 0; i < NUM_ROTORS; i++) begin
            if (rotor_inc_q[i]) begin
                stepped_pos[5*i +: 5] = (position_q[5*i +: 5] == ROTOR_LAST) ?
                                        5'd0 : position_q[5*i +: 5] + 5'd1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        step_cnt_d   = step_cnt_q;
        rotor_load_d = 1'b0;
        rotor_init_d = rotor_init_q;
        rotor_inc_d  = '0;
        position_d   = position_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    rotor_init_d = bus.init_state;
                    position_d   = bus.init_state;
                    step_cnt_d   = '0;
                    rotor_load_d = 1'b1;
                    state_d      = S_LOAD;
                end
            end
            S_LOAD: begin
                wait_d  = SETTLE_LD;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (wait_q <= 4'd1) begin
                    wait_d  = 4'd0;
                    state_d = S_CHECK;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_CHECK: begin
                if (bus.stop_in) begin
                    state_d = S_STOPPED;
                end else if (step_cnt_q == FINAL_CNT) begin
                    state_d = S_DONE;
                end else begin
                    rotor_inc_d = step_mask;
                    state_d     = S_STEP;
                end
            end
            S_STEP: begin
                position_d = stepped_pos;
                step_cnt_d = step_cnt_q + 1'b1;
                wait_d     = SETTLE_LD;
                state_d    = S_SETTLE;
            end
            S_STOPPED: begin
                if (bus.resume) begin
                    if (step_cnt_q == FINAL_CNT) begin
                        state_d = S_DONE;
                    end else begin
                        rotor_inc_d = step_mask;
                        state_d     = S_STEP;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // An increment pulse already on the wire still lands in the rotors, so the shadow follows it.
        if (bus.abort) begin
            state_d      = S_IDLE;
            wait_d       = 4'd0;
            step_cnt_d   = '0;
            rotor_load_d = 1'b0;
            rotor_inc_d  = '0;
            rotor_init_d = rotor_init_q;
            position_d   = (state_q == S_STEP) ? stepped_pos : position_q;
        end

        running_d  = (state_d == S_LOAD) || (state_d == S_SETTLE) ||
                     (state_d == S_CHECK) || (state_d == S_STEP);
        stop_hit_d = (state_d == S_STOPPED);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            wait_q       <= '0;
            step_cnt_q   <= '0;
            rotor_load_q <= 1'b0;
            rotor_init_q <= '0;
            rotor_inc_q  <= '0;
            position_q   <= '0;
            running_q    <= 1'b0;
            stop_hit_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            step_cnt_q   <= step_cnt_d;
            rotor_load_q <= rotor_load_d;
            rotor_init_q <= rotor_init_d;
            rotor_inc_q  <= rotor_inc_d;
            position_q   <= position_d;
            running_q    <= running_d;
            stop_hit_q   <= stop_hit_d;
            done_q       <= done_d;
        end
    end

`ifdef BOMBE_STOP_COUNT_EN
    logic [7:0] stop_count_q, stop_count_d;

    always_comb begin
        stop_count_d = stop_count_q;
        if (!bus.abort) begin
            if (((state_q == S_IDLE) || (state_q == S_DONE)) && bus.start) begin
                stop_count_d = 8'd0;
            end else if ((state_q == S_CHECK) && bus.stop_in && (stop_count_q != 8'hFF)) begin
                stop_count_d = stop_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stop_count_q <= 8'd0;
        end else begin
            stop_count_q <= stop_count_d;
        end
    end

    assign bus.stop_count = stop_count_q;
`else
    assign bus.stop_count = 8'd0;
`endif

    assign bus.rotor_load      = rotor_load_q;
    assign bus.rotor_init      = rotor_init_q;
    assign bus.rotor_increment = rotor_inc_q;
    assign bus.position        = position_q;
    assign bus.running         = running_q;
    assign bus.stop_hit        = stop_hit_q;
    assign bus.done            = done_q;

endmodule

// File: tb/tb_bombe_step_controller.sv
// Scoreboard bench for bombe_step_controller: stimulus queues expected rotor events, a monitor checks them.
module tb_bombe_step_controller;

    localparam int NR = 3;
    localparam int MOD = 26;
    localparam int SC = 2;

`ifdef BOMBE_STOP_COUNT_EN
    localparam bit SC_EN = 1'b1;
`else
    localparam bit SC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    bombe_step_if #(.NUM_ROTORS(NR)) bus();

    bombe_step_controller #(
        .NUM_ROTORS(NR), .ROTOR_MOD(MOD), .SETTLE_CYCLES(SC)
    ) dut (
        .clk(clk), .resetn(resetn), .bus(bus)
    );

    typedef enum int {E_LOAD, E_STEP, E_STOP, E_DONE} kind_t;
    typedef struct {
        kind_t      kind;
        logic [2:0] inc;
        logic [14:0] pos;
        logic [7:0] sc;
        int         gap;
    } ev_t;

    ev_t exp_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_load = 0;
    int n_step = 0;
    int last_pulse = 0;
    logic prev_stop = 1'b0;
    logic prev_done = 1'b0;
    ev_t mon_e;
    bit mon_ok;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [14:0] pk(input logic [4:0] r2, input logic [4:0] r1, input logic [4:0] r0);
        return {r2, r1, r0};
    endfunction

    function automatic logic [7:0] exp_sc(input int n);
        return SC_EN ? 8'(n) : 8'd0;
    endfunction

    function automatic void push(input kind_t k, input logic [2:0] inc, input logic [14:0] pos,
                                 input logic [7:0] sc, input int gap);
        ev_t e;
        e.kind = k; e.inc = inc; e.pos = pos; e.sc = sc; e.gap = gap;
        exp_q.push_back(e);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic take(input kind_t k, output ev_t e, output bit ok);
        ok = 1'b0;
        e  = '{E_LOAD, 3'd0, 15'd0, 8'd0, 0};
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL event: unexpected %s with empty queue at cycle %0d", k.name(), cyc);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", e.kind, k);
            ok = (e.kind == k);
        end
    endtask

    // Monitor: every rotor pulse and every entry into STOPPED/DONE consumes one expected event.
    always @(negedge clk) begin
        if (resetn) begin
            if (bus.rotor_load) begin
                n_load++;
                take(E_LOAD, mon_e, mon_ok);
                if (mon_ok) begin
                    check("load_position", bus.position, mon_e.pos);
                    check("load_rotor_init", bus.rotor_init, mon_e.pos);
                end
                last_pulse = cyc;
            end
            if (bus.rotor_increment != 3'd0) begin
                n_step++;
                take(E_STEP, mon_e, mon_ok);
                if (mon_ok) begin
                    check("step_increment", bus.rotor_increment, mon_e.inc);
                    check("step_position", bus.position, mon_e.pos);
                    if (mon_e.gap != 0) check("step_gap", cyc - last_pulse, mon_e.gap);
                end
                last_pulse = cyc;
            end
            if (bus.stop_hit && !prev_stop) begin
                take(E_STOP, mon_e, mon_ok);
                if (mon_ok) begin
                    check("stop_position", bus.position, mon_e.pos);
                    check("stop_count", bus.stop_count, mon_e.sc);
                end
            end
            if (bus.done && !prev_done) begin
                take(E_DONE, mon_e, mon_ok);
                if (mon_ok) check("done_position", bus.position, mon_e.pos);
            end
        end
        prev_stop = bus.stop_hit;
        prev_done = bus.done;
    end

    function automatic bit cond(input int w);
        case (w)
            0:       return bus.rotor_increment != 3'd0;
            1:       return bus.stop_hit;
            2:       return bus.done;
            default: return bus.rotor_load;
        endcase
    endfunction

    task automatic wait_on(input int w, input int max, input string nm);
        int n = 0;
        bit hit = cond(w);
        while (!hit && n < max) begin
            @(negedge clk);
            n++;
            hit = cond(w);
        end
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL %s: timeout after %0d cycles", nm, max);
        end
    endtask

    task automatic cyc_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input logic [14:0] init);
        @(negedge clk);
        bus.init_state = init;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic do_abort();
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
    endtask

    task automatic do_resume();
        @(negedge clk);
        bus.resume = 1'b1;
        @(negedge clk);
        bus.resume = 1'b0;
    endtask

    task automatic chk_idle(input string nm, input logic [14:0] pos, input logic [14:0] init,
                            input logic [7:0] sc);
        check({nm, "_ctl"}, {bus.rotor_load, bus.rotor_increment, bus.running, bus.stop_hit, bus.done}, 7'd0);
        check({nm, "_position"}, bus.position, pos);
        check({nm, "_rotor_init"}, bus.rotor_init, init);
        check({nm, "_stop_count"}, bus.stop_count, sc);
    endtask

    // Start, take one step, stop at the following CHECK, then abort out of STOPPED.
    task automatic step_case(input string nm, input logic [14:0] init, input logic [2:0] inc,
                             input logic [14:0] nxt);
        push(E_LOAD, 3'd0, init, 8'd0, 0);
        push(E_STEP, inc, init, 8'd0, SC + 2);
        push(E_STOP, 3'd0, nxt, exp_sc(1), 0);
        bus.stop_in = 1'b0;
        do_start(init);
        wait_on(0, 20, {nm, "_step_wait"});
        bus.stop_in = 1'b1;
        wait_on(1, 20, {nm, "_stop_wait"});
        bus.stop_in = 1'b0;
        do_abort();
        chk_idle({nm, "_abort"}, nxt, init, exp_sc(1));
        check({nm, "_queue_left"}, exp_q.size(), 0);
    endtask

    initial begin
        logic [4:0] r [3];
        logic [2:0] inc;
        int s0;

        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.resume = 1'b0;
        bus.stop_in = 1'b0;
        bus.init_state = '0;

        cyc_n(3);
        chk_idle("reset", 15'd0, 15'd0, 8'd0);
        resetn = 1'b1;
        cyc_n(2);

        step_case("load_123", pk(1, 2, 3), 3'b001, pk(1, 2, 4));
        step_case("carry_all", pk(0, 25, 25), 3'b111, pk(1, 0, 0));
        step_case("carry_two", pk(0, 24, 25), 3'b011, pk(0, 25, 0));

        // Stop at the first position, hold, resume into the next one and stop again.
        push(E_LOAD, 3'd0, pk(0, 0, 7), 8'd0, 0);
        push(E_STOP, 3'd0, pk(0, 0, 7), exp_sc(1), 0);
        bus.stop_in = 1'b1;
        do_start(pk(0, 0, 7));
        wait_on(1, 20, "stop_first_wait");
        bus.stop_in = 1'b0;
        cyc_n(5);
        check("stopped_hold", bus.stop_hit, 1'b1);
        push(E_STEP, 3'b001, pk(0, 0, 7), 8'd0, 0);
        push(E_STOP, 3'd0, pk(0, 0, 8), exp_sc(2), 0);
        do_resume();
        wait_on(0, 20, "resume_step_wait");
        bus.stop_in = 1'b1;
        wait_on(1, 20, "stop_second_wait");
        bus.stop_in = 1'b0;
        do_abort();
        chk_idle("abort_stopped", pk(0, 0, 8), pk(0, 0, 7), exp_sc(2));
        do_resume();
        cyc_n(5);
        chk_idle("resume_in_idle", pk(0, 0, 8), pk(0, 0, 7), exp_sc(2));
        check("stop_queue_left", exp_q.size(), 0);

        // Asynchronous reset while settling.
        push(E_LOAD, 3'd0, pk(0, 0, 5), 8'd0, 0);
        do_start(pk(0, 0, 5));
        cyc_n(1);
        check("pre_reset_running", bus.running, 1'b1);
        resetn = 1'b0;
        #1;
        chk_idle("async_reset", 15'd0, 15'd0, 8'd0);
        cyc_n(2);
        resetn = 1'b1;
        cyc_n(8);
        chk_idle("after_reset", 15'd0, 15'd0, 8'd0);
        check("reset_queue_left", exp_q.size(), 0);

        // Full sweep from {1,2,3}: odometer model generates every step.
        push(E_LOAD, 3'd0, pk(1, 2, 3), 8'd0, 0);
        r[2] = 5'd1; r[1] = 5'd2; r[0] = 5'd3;
        for (int k = 0; k < 17575; k++) begin
            inc[0] = 1'b1;
            inc[1] = (r[0] == 5'd25);
            inc[2] = (r[0] == 5'd25) && (r[1] == 5'd25);
            push(E_STEP, inc, {r[2], r[1], r[0]}, 8'd0, SC + 2);
            for (int i = 0; i < 3; i++) begin
                if (inc[i]) r[i] = (r[i] == 5'd25) ? 5'd0 : r[i] + 5'd1;
            end
        end
        push(E_DONE, 3'd0, pk(1, 2, 2), 8'd0, 0);
        s0 = n_step;
        bus.stop_in = 1'b0;
        do_start(pk(1, 2, 3));
        wait_on(2, 72000, "sweep_done_wait");
        check("sweep_steps", n_step - s0, 17575);
        cyc_n(3);
        check("done_hold", bus.done, 1'b1);
        check("done_running", bus.running, 1'b0);

        // Re-arm from DONE.
        push(E_LOAD, 3'd0, pk(0, 0, 1), 8'd0, 0);
        push(E_STOP, 3'd0, pk(0, 0, 1), exp_sc(1), 0);
        bus.stop_in = 1'b1;
        do_start(pk(0, 0, 1));
        check("rearm_done_cleared", bus.done, 1'b0);
        wait_on(1, 20, "rearm_stop_wait");
        bus.stop_in = 1'b0;
        do_abort();
        chk_idle("rearm_abort", pk(0, 0, 1), pk(0, 0, 1), exp_sc(1));
        check("final_queue_left", exp_q.size(), 0);
        check("load_pulses", n_load, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
